// File: rtl/pc_sequencer_pkg.sv
// Shared types and default vectors for the fetch-address sequencer.
// Imported by the RAS sub-module and the sequencer top.
package pc_sequencer_pkg;

    localparam logic [31:0] DEF_RESET_VEC = 32'h0000_3000;
    localparam logic [31:0] DEF_EXC_VEC   = 32'h0000_0800;

    typedef enum logic [2:0] {
        SEL_SEQ,
        SEL_BR,
        SEL_J,
        SEL_JR,
        SEL_ERET,
        SEL_EXC
    } pc_sel_e;

endpackage

// File: rtl/pc_sequencer_if.sv
// Fetch request channel: sequencer drives pc/pc_valid, imem returns pc_ready.
// The master side is the sequencer.
interface pc_sequencer_if #(
    parameter int ADDR_W = 32
);
    logic [ADDR_W-1:0] pc;
    logic              pc_valid;
    logic              pc_ready;

    modport master (output pc, pc_valid, input pc_ready);
    modport slave  (input pc, pc_valid, output pc_ready);
endinterface

// File: rtl/pc_sequencer_ras.sv
// Circular return-address stack; a push when full overwrites the oldest entry.
// A simultaneous push and pop replaces the top entry in place.
module pc_sequencer_ras #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] data,
    output logic [ADDR_W-1:0] top,
    output logic              empty
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

    logic [ADDR_W-1:0] mem [DEPTH];
    logic [PW-1:0]     ptr;
    logic [PW:0]       count;
    logic [PW-1:0]     waddr;
    logic              we;

    assign we    = reset & push;
    assign waddr = pop ? ptr : ptr + 1'b1;
    assign empty = (count == '0);
    assign top   = empty ? '0 : mem[ptr];

    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= data;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ptr   <= '0;
            count <= '0;
        end else if (push && !pop) begin
            ptr <= ptr + 1'b1;
            if (count != FULL)
                count <= count + 1'b1;
        end else if (pop && !push && !empty) begin
            ptr   <= ptr - 1'b1;
            count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-address sequencer: next-PC priority mux, EPC with nested-exception
// protection, fetch handshake with stall, and a return-address stack.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int          ADDR_W    = 32,
    parameter logic [31:0] RESET_VEC = DEF_RESET_VEC,
    parameter logic [31:0] EXC_VEC   = DEF_EXC_VEC,
    parameter int          RAS_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    pc_sequencer_if.master    fetch,
    input  logic              stall,
    input  logic              branch,
    input  logic              equal,
    input  logic              bne,
    input  logic [15:0]       br_off,
    input  logic              jump,
    input  logic [25:0]       jidx,
    input  logic              is_jr,
    input  logic [ADDR_W-1:0] jr_addr,
    input  logic              is_call,
    input  logic              is_ret,
    input  logic              exc,
    input  logic              eret,
    output logic [ADDR_W-1:0] epc,
    output logic              in_exc,
    output logic              misalign,
    output logic [ADDR_W-1:0] ras_top,
    output logic              ras_empty
);
    logic [ADDR_W-1:0] pc_q, epc_q, nxt;
    logic [ADDR_W-1:0] pc4, br_tgt, j_tgt, jr_tgt;
    logic              valid_q, in_exc_q, mis_q;
    logic              adv, taken, upd, ras_act;
    pc_sel_e           sel;

    assign adv    = valid_q & fetch.pc_ready & ~stall;
    assign taken  = branch & (equal ^ bne);
    assign pc4    = pc_q + ADDR_W'(4);
    assign br_tgt = pc4 + {{(ADDR_W-18){br_off[15]}}, br_off, 2'b00};
    assign jr_tgt = {jr_addr[ADDR_W-1:2], 2'b00};

    // Upper region bits come from pc4; only the low 28 bits are replaced.
    always_comb begin
        j_tgt       = pc4;
        j_tgt[27:0] = {jidx, 2'b00};
    end

    always_comb begin
        sel = SEL_SEQ;
        upd = 1'b1;
        if (exc)                   sel = SEL_EXC;
        else if (eret && in_exc_q) sel = SEL_ERET;
        else if (!adv)             upd = 1'b0;
        else if (is_jr)            sel = SEL_JR;
        else if (jump)             sel = SEL_J;
        else if (taken)            sel = SEL_BR;
    end

    always_comb begin
        nxt = pc4;
        unique case (sel)
            SEL_EXC:  nxt = EXC_VEC[ADDR_W-1:0];
            SEL_ERET: nxt = epc_q;
            SEL_JR:   nxt = jr_tgt;
            SEL_J:    nxt = j_tgt;
            SEL_BR:   nxt = br_tgt;
            SEL_SEQ:  nxt = pc4;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_q     <= RESET_VEC[ADDR_W-1:0];
            valid_q  <= 1'b0;
            epc_q    <= '0;
            in_exc_q <= 1'b0;
            mis_q    <= 1'b0;
        end else begin
            valid_q <= 1'b1;
            mis_q   <= (sel == SEL_JR) && (jr_addr[1:0] != 2'b00);
            if (upd)
                pc_q <= nxt;
            // A nested exception keeps the outer return address.
            if (sel == SEL_EXC) begin
                in_exc_q <= 1'b1;
                if (!in_exc_q)
                    epc_q <= pc_q;
            end else if (sel == SEL_ERET) begin
                in_exc_q <= 1'b0;
            end
        end
    end

    assign ras_act = adv & ~exc;

    pc_sequencer_ras #(
        .DEPTH  (RAS_DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ras (
        .clk   (clk),
        .reset (reset),
        .push  (ras_act & is_call),
        .pop   (ras_act & is_ret),
        .data  (pc4),
        .top   (ras_top),
        .empty (ras_empty)
    );

    assign fetch.pc       = pc_q;
    assign fetch.pc_valid = valid_q;
    assign epc            = epc_q;
    assign in_exc         = in_exc_q;
    assign misalign       = mis_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: handshake, redirects, exceptions and RAS.
// Expected values are hand-computed constants.
module tb_pc_sequencer;
    logic        clk = 1'b0;
    logic        reset;
    logic        stall, branch, equal, bne, jump, is_jr;
    logic        is_call, is_ret, exc, eret;
    logic [15:0] br_off;
    logic [25:0] jidx;
    logic [31:0] jr_addr;
    logic [31:0] epc, ras_top;
    logic        in_exc, misalign, ras_empty;

    int vectors = 0;
    int errors  = 0;

    pc_sequencer_if #(.ADDR_W(32)) fif ();

    pc_sequencer dut (
        .clk       (clk),
        .reset     (reset),
        .fetch     (fif.master),
        .stall     (stall),
        .branch    (branch),
        .equal     (equal),
        .bne       (bne),
        .br_off    (br_off),
        .jump      (jump),
        .jidx      (jidx),
        .is_jr     (is_jr),
        .jr_addr   (jr_addr),
        .is_call   (is_call),
        .is_ret    (is_ret),
        .exc       (exc),
        .eret      (eret),
        .epc       (epc),
        .in_exc    (in_exc),
        .misalign  (misalign),
        .ras_top   (ras_top),
        .ras_empty (ras_empty)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b0; stall = 1'b0; branch = 1'b0; equal = 1'b0;
        bne = 1'b0; jump = 1'b0; is_jr = 1'b0; is_call = 1'b0;
        is_ret = 1'b0; exc = 1'b0; eret = 1'b0; br_off = '0;
        jidx = '0; jr_addr = '0; fif.pc_ready = 1'b1;

        repeat (2) step();
        chk("rst_pc", fif.pc, 32'h3000);
        chk("rst_valid", 32'(fif.pc_valid), 0);
        chk("rst_epc", epc, 0);
        chk("rst_in_exc", 32'(in_exc), 0);
        chk("rst_misalign", 32'(misalign), 0);
        chk("rst_ras_empty", 32'(ras_empty), 1);
        chk("rst_ras_top", ras_top, 0);

        reset = 1'b1;
        step();
        chk("rel_pc", fif.pc, 32'h3000);
        chk("rel_valid", 32'(fif.pc_valid), 1);
        step();
        chk("seq1", fif.pc, 32'h3004);
        step();
        chk("seq2", fif.pc, 32'h3008);

        branch = 1'b1; equal = 1'b1; bne = 1'b0; br_off = 16'd4;
        step();
        chk("beq_taken", fif.pc, 32'h301C);
        branch = 1'b0;

        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_hold", fif.pc, 32'h301C);
        end
        stall = 1'b0;
        fif.pc_ready = 1'b0;
        step();
        chk("notready_hold", fif.pc, 32'h301C);
        fif.pc_ready = 1'b1;

        branch = 1'b1; equal = 1'b1; bne = 1'b1;
        step();
        chk("bne_not_taken", fif.pc, 32'h3020);
        branch = 1'b0;

        is_jr = 1'b1; jr_addr = 32'hCAFE_BABE;
        step();
        chk("jr_pc", fif.pc, 32'hCAFE_BABC);
        chk("jr_misalign", 32'(misalign), 1);
        is_jr = 1'b0;
        step();
        chk("seq_after_jr", fif.pc, 32'hCAFE_BAC0);
        chk("misalign_pulse", 32'(misalign), 0);

        branch = 1'b1; equal = 1'b0; bne = 1'b1; br_off = 16'hFFFE;
        step();
        chk("bne_neg_off", fif.pc, 32'hCAFE_BABC);
        branch = 1'b0;

        jump = 1'b1; jidx = 26'h3FF_FFFF;
        step();
        chk("jump_region", fif.pc, 32'hCFFF_FFFC);

        is_jr = 1'b1; jr_addr = 32'h3040; jidx = '0;
        step();
        chk("jr_over_jump", fif.pc, 32'h3040);
        chk("jr_aligned", 32'(misalign), 0);
        is_jr = 1'b0; jump = 1'b0;

        exc = 1'b1; stall = 1'b1; fif.pc_ready = 1'b0;
        step();
        chk("exc_pc", fif.pc, 32'h0800);
        chk("exc_epc", epc, 32'h3040);
        chk("exc_in_exc", 32'(in_exc), 1);
        step();
        chk("nested_pc", fif.pc, 32'h0800);
        chk("nested_epc", epc, 32'h3040);
        exc = 1'b0; eret = 1'b1;
        step();
        chk("eret_pc", fif.pc, 32'h3040);
        chk("eret_in_exc", 32'(in_exc), 0);
        step();
        chk("eret_ignored", fif.pc, 32'h3040);
        eret = 1'b0; stall = 1'b0; fif.pc_ready = 1'b1;

        jump = 1'b1; jidx = 26'h000_0C00;
        step();
        chk("jump_pc", fif.pc, 32'h3000);
        jump = 1'b0;

        is_call = 1'b1; is_jr = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            jr_addr = 32'h3000 + 32'(i) * 32'h10;
            step();
        end
        is_jr = 1'b0;
        chk("call_pc", fif.pc, 32'h3050);
        chk("ras_top_full", ras_top, 32'h3044);
        chk("ras_nonempty", 32'(ras_empty), 0);

        is_ret = 1'b1;
        step();
        chk("ras_replace", ras_top, 32'h3054);
        is_call = 1'b0;
        step();
        chk("ret1", ras_top, 32'h3034);
        step();
        chk("ret2", ras_top, 32'h3024);
        step();
        chk("ret3", ras_top, 32'h3014);
        step();
        chk("ret4_empty", 32'(ras_empty), 1);
        chk("ret4_top", ras_top, 0);
        step();
        chk("ret5_underflow", 32'(ras_empty), 1);
        is_ret = 1'b0;

        is_jr = 1'b1; jr_addr = 32'hFFFF_FFFC;
        step();
        is_jr = 1'b0;
        step();
        chk("pc4_wrap", fif.pc, 32'h0000_0000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
